sb_frame_deserializer: RTL and testbench



---
 rtl/sb_pkg.sv | 14 +
 rtl/sb_frame_deserializer_if.sv | 24 ++
 rtl/sb_shift_reg.sv | 53 +++++
 rtl/sb_frame_deserializer.sv | 124 ++++++++++++
 tb/tb_sb_frame_deserializer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the USB4 sideband frame deserializer.
package sb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } sb_state_e;

    localparam logic SB_START_BIT     = 1'b0;
    localparam logic SB_STOP_BIT      = 1'b1;
    localparam int   SB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sb_frame_deserializer_if.sv
// Serial-in / parallel-out bundle between the sideband line receiver and the transaction decoder.
interface sb_frame_deserializer_if
    import sb_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DEFAULT_WIDTH
);
    logic                  enable;
    logic                  bit_valid;
    logic                  in_bit;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  framing_error;
    logic                  busy;

    modport master (
        output enable, bit_valid, in_bit,
        input  parallel_data, data_valid, framing_error, busy
    );

    modport slave (
        input  enable, bit_valid, in_bit,
        output parallel_data, data_valid, framing_error, busy
    );
endinterface

// File: rtl/sb_shift_reg.sv
// Serial shift register plus the holding word presented as parallel_data.
// load captures the post-shift value, so a shift and a load in one cycle include the current bit.
module sb_shift_reg
    import sb_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DEFAULT_WIDTH,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  in_bit,
    output logic [DATA_WIDTH-1:0] word
);
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] word_reg;

    // LSB-first enters at the MSB so the first bit ends up in bit 0 after DATA_WIDTH shifts.
    if (LSB_FIRST) begin : g_lsb_first
        assign shifted = {in_bit, shift_reg[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
        assign shifted = {shift_reg[DATA_WIDTH-2:0], in_bit};
    end

    always_comb begin
        shift_next = shift_reg;
        if (shift_en) begin
            shift_next = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            word_reg  <= '0;
        end else begin
            if (clear) begin
                shift_reg <= '0;
            end else begin
                shift_reg <= shift_next;
            end
            if (load) begin
                word_reg <= shift_next;
            end
        end
    end

    assign word = word_reg;
endmodule

// File: rtl/sb_frame_deserializer.sv
// Sideband serial-to-parallel deserializer: start/data/stop framing or free-running word slicing.
module sb_frame_deserializer
    import sb_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DEFAULT_WIDTH,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit FRAMED     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    sb_frame_deserializer_if.slave  bus
);
    localparam int             CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

    sb_state_e             state_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  data_valid_reg;
    logic                  framing_error_reg;
    logic                  busy_reg;
    logic                  qualified;
    logic                  cnt_last;
    logic                  shift_en;
    logic                  load;
    logic                  clear;
    logic [DATA_WIDTH-1:0] word;

    assign qualified = bus.enable & bus.bit_valid;
    assign cnt_last  = (cnt_reg == CNT_LAST);

    always_comb begin
        shift_en = 1'b0;
        load     = 1'b0;
        clear    = 1'b0;
        if (FRAMED) begin
            if (qualified) begin
                case (state_reg)
                    IDLE:    clear    = (bus.in_bit == SB_START_BIT);
                    DATA:    shift_en = 1'b1;
                    STOP:    load     = (bus.in_bit == SB_STOP_BIT);
                    default: clear    = 1'b0;
                endcase
            end
        end else begin
            shift_en = qualified;
            load     = qualified & cnt_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            data_valid_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            data_valid_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
            if (!bus.enable) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                busy_reg  <= 1'b0;
            end else if (bus.bit_valid) begin
                if (FRAMED) begin
                    case (state_reg)
                        IDLE: begin
                            if (bus.in_bit == SB_START_BIT) begin
                                state_reg <= DATA;
                                cnt_reg   <= '0;
                                busy_reg  <= 1'b1;
                            end
                        end
                        DATA: begin
                            if (cnt_last) begin
                                state_reg <= STOP;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        STOP: begin
                            // A bad stop bit is consumed here; it never doubles as the next start bit.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            if (bus.in_bit == SB_STOP_BIT) begin
                                data_valid_reg <= 1'b1;
                            end else begin
                                framing_error_reg <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b0;
                        end
                    endcase
                end else begin
                    data_valid_reg <= cnt_last;
                    cnt_reg        <= cnt_last ? '0 : cnt_reg + 1'b1;
                end
            end
        end
    end

    sb_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .load     (load),
        .clear    (clear),
        .in_bit   (bus.in_bit),
        .word     (word)
    );

    assign bus.parallel_data = word;
    assign bus.data_valid    = data_valid_reg;
    assign bus.framing_error = framing_error_reg;
    // Free-running mode has no frame state; it is busy whenever it is listening.
    assign bus.busy          = FRAMED ? busy_reg : (bus.enable & rst);
endmodule

// File: tb/tb_sb_frame_deserializer.sv
// Bench for sb_frame_deserializer: three configurations checked every cycle against a bit-collecting model.
module tb_sb_frame_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cfg_w[3]   = '{8, 8, 16};
    int cfg_lsb[3] = '{1, 0, 1};
    int cfg_fr[3]  = '{1, 1, 0};

    logic en[3];
    logic bv[3];
    logic ib[3];

    int checks = 0;
    int errors = 0;
    int qcnt   = 0;

    sb_frame_deserializer_if #(.DATA_WIDTH(8))  bus0();
    sb_frame_deserializer_if #(.DATA_WIDTH(8))  bus1();
    sb_frame_deserializer_if #(.DATA_WIDTH(16)) bus2();

    assign bus0.enable = en[0]; assign bus0.bit_valid = bv[0]; assign bus0.in_bit = ib[0];
    assign bus1.enable = en[1]; assign bus1.bit_valid = bv[1]; assign bus1.in_bit = ib[1];
    assign bus2.enable = en[2]; assign bus2.bit_valid = bv[2]; assign bus2.in_bit = ib[2];

    sb_frame_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .FRAMED(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    sb_frame_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .FRAMED(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    sb_frame_deserializer #(.DATA_WIDTH(16), .LSB_FIRST(1'b1), .FRAMED(1'b0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    logic [31:0] act_pd[3];
    logic        act_dv[3];
    logic        act_fe[3];
    logic        act_busy[3];

    always_comb begin
        act_pd[0] = 32'(bus0.parallel_data);
        act_pd[1] = 32'(bus1.parallel_data);
        act_pd[2] = 32'(bus2.parallel_data);
        act_dv[0] = bus0.data_valid;    act_dv[1] = bus1.data_valid;    act_dv[2] = bus2.data_valid;
        act_fe[0] = bus0.framing_error; act_fe[1] = bus1.framing_error; act_fe[2] = bus2.framing_error;
        act_busy[0] = bus0.busy;        act_busy[1] = bus1.busy;        act_busy[2] = bus2.busy;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, d, a, e, $time);
        end
    endtask

    // Model: collect qualified bits into a frame buffer; a frame is done once start+data+stop
    // bits (or, free-running, DATA_WIDTH bits) have been gathered.
    logic [33:0] acc[3];
    int          fill[3];
    logic [31:0] exp_pd[3];
    logic        exp_dv[3];
    logic        exp_fe[3];

    function automatic logic [31:0] assemble(input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < cfg_w[d]; i++) begin
            int src;
            int pos;
            src = (cfg_fr[d] != 0) ? i + 1 : i;
            pos = (cfg_lsb[d] != 0) ? i : cfg_w[d] - 1 - i;
            r[pos] = acc[d][src];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                fill[d]   = 0;
                exp_pd[d] = '0;
                exp_dv[d] = 1'b0;
                exp_fe[d] = 1'b0;
            end else begin
                exp_dv[d] = 1'b0;
                exp_fe[d] = 1'b0;
                if (!en[d]) begin
                    fill[d] = 0;
                end else if (bv[d]) begin
                    if (!(cfg_fr[d] != 0 && fill[d] == 0 && ib[d] == 1'b1)) begin
                        acc[d][fill[d]] = ib[d];
                        fill[d]++;
                        if (cfg_fr[d] != 0 && fill[d] == cfg_w[d] + 2) begin
                            if (ib[d]) begin
                                exp_pd[d] = assemble(d);
                                exp_dv[d] = 1'b1;
                            end else begin
                                exp_fe[d] = 1'b1;
                            end
                            fill[d] = 0;
                        end else if (cfg_fr[d] == 0 && fill[d] == cfg_w[d]) begin
                            exp_pd[d] = assemble(d);
                            exp_dv[d] = 1'b1;
                            fill[d]   = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic exp_busy;
            exp_busy = (cfg_fr[d] != 0) ? (fill[d] > 0) : (en[d] && rst);
            chk("pd", d, act_pd[d], exp_pd[d]);
            chk("dv", d, 32'(act_dv[d]), 32'(exp_dv[d]));
            chk("fe", d, 32'(act_fe[d]), 32'(exp_fe[d]));
            chk("busy", d, 32'(act_busy[d]), 32'(exp_busy));
        end
    end

    task automatic tick(input int d, input logic v, input logic b);
        bv[d] = v;
        ib[d] = b;
        @(posedge clk);
        if (v && en[d]) qcnt++;
        #1;
    endtask

    task automatic qbit(input int d, input logic b, input bit alt);
        if (alt) tick(d, 1'b0, ~b);
        tick(d, 1'b1, b);
    endtask

    task automatic send(input int d, input logic [31:0] val, input logic stopb,
                        input bit alt, input bit mid_gap);
        $display("send dut%0d value=%h stop=%0b gaps=%0b", d, val, stopb, alt | mid_gap);
        if (cfg_fr[d] != 0) qbit(d, 1'b0, alt);
        for (int i = 0; i < cfg_w[d]; i++) begin
            if (mid_gap && i == 4) repeat (5) tick(d, 1'b0, 1'b0);
            qbit(d, (cfg_lsb[d] != 0) ? val[i] : val[cfg_w[d] - 1 - i], alt);
        end
        if (cfg_fr[d] != 0) qbit(d, stopb, alt);
    endtask

    task automatic partial(input int d, input logic [31:0] val);
        tick(d, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(d, 1'b1, val[i]);
    endtask

    initial begin
        int q1;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b0; bv[d] = 1'b0; ib[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pd", 0, act_pd[0], 32'h0);
        chk("reset_busy", 0, 32'(act_busy[0]), 32'h0);
        rst = 1'b1;
        en[0] = 1'b1;
        tick(0, 1'b1, 1'b1);
        tick(0, 1'b1, 1'b1);

        send(0, 32'h5A, 1'b1, 1'b0, 1'b0);
        chk("lit_5a_dv", 0, 32'(act_dv[0]), 32'h1);
        chk("lit_5a_pd", 0, act_pd[0], 32'h5A);
        tick(0, 1'b1, 1'b1);
        chk("lit_5a_dv_drop", 0, 32'(act_dv[0]), 32'h0);

        send(0, 32'hC3, 1'b0, 1'b0, 1'b0);
        chk("lit_ferr_fe", 0, 32'(act_fe[0]), 32'h1);
        chk("lit_ferr_pd_held", 0, act_pd[0], 32'h5A);
        send(0, 32'hA5, 1'b1, 1'b0, 1'b0);
        chk("lit_a5_pd", 0, act_pd[0], 32'hA5);

        send(0, 32'h01, 1'b1, 1'b0, 1'b0);
        chk("lit_b2b_first", 0, act_pd[0], 32'h01);
        q1 = qcnt;
        send(0, 32'hFF, 1'b1, 1'b0, 1'b0);
        chk("lit_b2b_second_dv", 0, 32'(act_dv[0]), 32'h1);
        chk("lit_b2b_second", 0, act_pd[0], 32'hFF);
        chk("lit_b2b_spacing", 0, 32'(qcnt - q1), 32'd10);

        send(0, 32'h3C, 1'b1, 1'b1, 1'b1);
        chk("lit_gap_lsb", 0, act_pd[0], 32'h3C);
        bv[0] = 1'b0; en[0] = 1'b0; en[1] = 1'b1;
        tick(1, 1'b1, 1'b1);
        send(1, 32'h3C, 1'b1, 1'b1, 1'b1);
        chk("lit_gap_msb", 1, act_pd[1], 32'h3C);
        bv[1] = 1'b0; en[1] = 1'b0; en[0] = 1'b1;

        tick(0, 1'b1, 1'b1);
        partial(0, 32'h77);
        chk("lit_abort_busy_pre", 0, 32'(act_busy[0]), 32'h1);
        en[0] = 1'b0;
        tick(0, 1'b1, 1'b1);
        chk("lit_abort_busy", 0, 32'(act_busy[0]), 32'h0);
        en[0] = 1'b1;
        tick(0, 1'b1, 1'b1);
        send(0, 32'h77, 1'b1, 1'b0, 1'b0);
        chk("lit_after_abort", 0, act_pd[0], 32'h77);

        tick(0, 1'b1, 1'b1);
        partial(0, 32'h99);
        rst = 1'b0;
        #1;
        chk("lit_rst_busy", 0, 32'(act_busy[0]), 32'h0);
        chk("lit_rst_pd", 0, act_pd[0], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(0, 1'b1, 1'b1);
        send(0, 32'h77, 1'b1, 1'b0, 1'b0);
        chk("lit_after_rst", 0, act_pd[0], 32'h77);

        bv[0] = 1'b0; en[0] = 1'b0; en[2] = 1'b1;
        send(2, 32'h1234, 1'b1, 1'b0, 1'b0);
        chk("lit_free_1234", 2, act_pd[2], 32'h1234);
        send(2, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        chk("lit_free_beef_dv", 2, 32'(act_dv[2]), 32'h1);
        chk("lit_free_beef", 2, act_pd[2], 32'hBEEF);
        bv[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
